// File: rtl/pong_game_engine.sv
// Frame-stepped GuitarPong game-state engine: ball, paddles, scores and match FSM.
// Optional PONG_SPIN_EN: paddle hits set vy from the contact position on the paddle.
module pong_game_engine #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_STEP = 4,
  parameter int SPEED_INIT  = 2,
  parameter int SPEED_MAX   = 8,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 9,
  parameter int SCORE_W     = 4
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic               iFRAME_TICK,
  input  logic               iSTART,
  input  logic               pL_moveup,
  input  logic               pL_movedown,
  input  logic               pR_moveup,
  input  logic               pR_movedown,
  output logic [9:0]         oBALL_X,
  output logic [9:0]         oBALL_Y,
  output logic [9:0]         oPADL_Y,
  output logic [9:0]         oPADR_Y,
  output logic [SCORE_W-1:0] oSCORE_L,
  output logic [SCORE_W-1:0] oSCORE_R,
  output logic [2:0]         oSTATE,
  output logic               oHIT,
  output logic               oGAME_OVER
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic signed [10:0] C_BALL_X0 = 11'((H_RES - BALL_SIZE) / 2);
  localparam logic signed [10:0] C_BALL_Y0 = 11'((V_RES - BALL_SIZE) / 2);
  localparam logic signed [10:0] C_PAD0    = 11'((V_RES - PADDLE_H) / 2);
  localparam logic signed [10:0] C_PAD_MAX = 11'(V_RES - PADDLE_H);
  localparam logic signed [10:0] C_Y_MAX   = 11'(V_RES - BALL_SIZE);
  localparam logic signed [10:0] C_PW      = 11'(PADDLE_W);
  localparam logic signed [10:0] C_PH      = 11'(PADDLE_H);
  localparam logic signed [10:0] C_BS      = 11'(BALL_SIZE);
  localparam logic signed [10:0] C_STEP    = 11'(PADDLE_STEP);
  localparam logic signed [10:0] C_RX_LIM  = 11'(H_RES - PADDLE_W);
  localparam logic signed [10:0] C_RHIT_X  = 11'(H_RES - PADDLE_W - BALL_SIZE);
  localparam logic signed [5:0]  C_SPD0    = 6'(SPEED_INIT);
  localparam logic signed [5:0]  C_SPD_MAX = 6'(SPEED_MAX);
  localparam logic [SCORE_W-1:0] C_WIN     = SCORE_W'(WIN_SCORE);
  localparam int                 CNT_W     = $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0]   C_CNT_END = CNT_W'(SERVE_DELAY - 1);

  state_t              r_state;
  logic signed [10:0]  r_ball_x, r_ball_y, r_padl, r_padr;
  logic signed [5:0]   r_vx, r_vy;
  logic [SCORE_W-1:0]  r_score_l, r_score_r;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_serve_left;
  logic                r_hit;

  logic signed [10:0]  w_vx_ext, w_vy_ext, w_nx, w_ny;
  logic signed [10:0]  w_ball_x_play, w_ball_y_play, w_padl_next, w_padr_next;
  logic signed [5:0]   w_vx_abs, w_spd_next, w_vx_play, w_vy_play;
  logic                w_left_evt, w_right_evt, w_left_ovl, w_right_ovl;
  logic                w_hit, w_miss_l, w_miss_r;
  logic [SCORE_W-1:0]  w_score_l_inc, w_score_r_inc;

  function automatic logic signed [10:0] paddle_next(input logic signed [10:0] y,
                                                     input logic up, input logic dn);
    logic signed [10:0] t;
    t = y;
    if (up && !dn)      t = y - C_STEP;
    else if (dn && !up) t = y + C_STEP;
    if (t < 11'sd0)          t = 11'sd0;
    else if (t > C_PAD_MAX)  t = C_PAD_MAX;
    return t;
  endfunction

`ifdef PONG_SPIN_EN
  localparam logic signed [10:0] C_BS_HALF = 11'(BALL_SIZE / 2);
  localparam logic signed [10:0] C_Q1      = 11'(PADDLE_H / 4);
  localparam logic signed [10:0] C_Q2      = 11'(PADDLE_H / 2);
  localparam logic signed [10:0] C_Q3      = 11'((3 * PADDLE_H) / 4);

  // Contact offsets that fall slightly outside the paddle fold into the end quarters.
  function automatic logic signed [5:0] spin_vy(input logic signed [10:0] by,
                                                input logic signed [10:0] py);
    logic signed [10:0] d;
    d = by + C_BS_HALF - py;
    if (d < C_Q1)      return -6'sd2;
    else if (d < C_Q2) return -6'sd1;
    else if (d < C_Q3) return 6'sd1;
    else               return 6'sd2;
  endfunction
`endif

  always_comb begin
    w_padl_next   = paddle_next(r_padl, pL_moveup, pL_movedown);
    w_padr_next   = paddle_next(r_padr, pR_moveup, pR_movedown);
    w_vx_ext      = {{5{r_vx[5]}}, r_vx};
    w_vy_ext      = {{5{r_vy[5]}}, r_vy};
    w_nx          = r_ball_x + w_vx_ext;
    w_ny          = r_ball_y + w_vy_ext;
    w_vx_abs      = r_vx[5] ? -r_vx : r_vx;
    w_spd_next    = (w_vx_abs >= C_SPD_MAX) ? C_SPD_MAX : w_vx_abs + 6'sd1;
    w_score_l_inc = (r_score_l >= C_WIN) ? C_WIN : r_score_l + SCORE_W'(1);
    w_score_r_inc = (r_score_r >= C_WIN) ? C_WIN : r_score_r + SCORE_W'(1);

    w_ball_y_play = w_ny;
    w_vy_play     = r_vy;
    if (w_ny < 11'sd0) begin
      w_ball_y_play = -w_ny;
      w_vy_play     = -r_vy;
    end else if (w_ny > C_Y_MAX) begin
      w_ball_y_play = (C_Y_MAX <<< 1) - w_ny;
      w_vy_play     = -r_vy;
    end

    w_left_ovl  = (r_ball_y + C_BS > r_padl) && (r_ball_y < r_padl + C_PH);
    w_right_ovl = (r_ball_y + C_BS > r_padr) && (r_ball_y < r_padr + C_PH);
    w_left_evt  = r_vx[5] && (w_nx < C_PW);
    w_right_evt = !r_vx[5] && (r_vx != 6'sd0) && (w_nx + C_BS > C_RX_LIM);

    // Paddle handling runs after the wall fold so a corner contact applies both.
    w_ball_x_play = w_nx;
    w_vx_play     = r_vx;
    w_hit         = 1'b0;
    w_miss_l      = 1'b0;
    w_miss_r      = 1'b0;
    if (w_left_evt) begin
      if (w_left_ovl) begin
        w_hit         = 1'b1;
        w_ball_x_play = C_PW;
        w_vx_play     = w_spd_next;
`ifdef PONG_SPIN_EN
        w_vy_play     = spin_vy(r_ball_y, r_padl);
`endif
      end else begin
        w_miss_l = 1'b1;
      end
    end else if (w_right_evt) begin
      if (w_right_ovl) begin
        w_hit         = 1'b1;
        w_ball_x_play = C_RHIT_X;
        w_vx_play     = -w_spd_next;
`ifdef PONG_SPIN_EN
        w_vy_play     = spin_vy(r_ball_y, r_padr);
`endif
      end else begin
        w_miss_r = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state      <= S_IDLE;
      r_ball_x     <= C_BALL_X0;
      r_ball_y     <= C_BALL_Y0;
      r_padl       <= C_PAD0;
      r_padr       <= C_PAD0;
      r_vx         <= C_SPD0;
      r_vy         <= 6'sd1;
      r_score_l    <= '0;
      r_score_r    <= '0;
      r_cnt        <= '0;
      r_serve_left <= 1'b0;
      r_hit        <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      if (iFRAME_TICK) begin
        if (r_state != S_OVER) begin
          r_padl <= w_padl_next;
          r_padr <= w_padr_next;
        end
        case (r_state)
          S_IDLE, S_OVER: begin
            if (iSTART) begin
              r_score_l    <= '0;
              r_score_r    <= '0;
              r_serve_left <= 1'b0;
              r_state      <= S_SERVE;
            end
          end
          S_SERVE: begin
            r_ball_x <= C_BALL_X0;
            r_ball_y <= C_BALL_Y0;
            r_vx     <= r_serve_left ? -C_SPD0 : C_SPD0;
            r_vy     <= 6'sd1;
            r_state  <= S_PLAY;
          end
          S_PLAY: begin
            if (w_miss_l || w_miss_r) begin
              r_ball_x <= C_BALL_X0;
              r_ball_y <= C_BALL_Y0;
              r_cnt    <= '0;
              // The conceding side receives the next serve.
              r_serve_left <= w_miss_l;
              if (w_miss_l) begin
                r_score_r <= w_score_r_inc;
                r_state   <= (w_score_r_inc == C_WIN) ? S_OVER : S_POINT;
              end else begin
                r_score_l <= w_score_l_inc;
                r_state   <= (w_score_l_inc == C_WIN) ? S_OVER : S_POINT;
              end
            end else begin
              r_ball_x <= w_ball_x_play;
              r_ball_y <= w_ball_y_play;
              r_vx     <= w_vx_play;
              r_vy     <= w_vy_play;
              r_hit    <= w_hit;
            end
          end
          S_POINT: begin
            if (r_cnt == C_CNT_END) begin
              r_state <= S_SERVE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign oBALL_X    = r_ball_x[9:0];
  assign oBALL_Y    = r_ball_y[9:0];
  assign oPADL_Y    = r_padl[9:0];
  assign oPADR_Y    = r_padr[9:0];
  assign oSCORE_L   = r_score_l;
  assign oSCORE_R   = r_score_r;
  assign oSTATE     = r_state;
  assign oHIT       = r_hit;
  assign oGAME_OVER = (r_state == S_OVER);

endmodule
